// File: rtl/exhaustive_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : exhaustive_sweep_checker
// Description : Clocked exhaustive two-operand sweep engine. Walks every
//               (a, b) pair (b inner, a outer, both ascending from 0), holds
//               each vector for HOLD_CYCLES settle cycles, then compares the
//               DUT result against a golden-model result. Counts mismatches,
//               records the first failing vector and reports pass/fail.
//               Optional macro EXHAUSTIVE_SWEEP_STOP_ON_FAIL_EN ends the sweep
//               at the first mismatch, freezing the failing vector.
// Revision    : 1.0 - initial release
// ============================================================================
module exhaustive_sweep_checker #(
    parameter int WIDTH_A     = 3,
    parameter int WIDTH_B     = 3,
    parameter int WIDTH_Y     = 3,
    parameter int HOLD_CYCLES = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [WIDTH_A-1:0]         stim_a,
    output logic [WIDTH_B-1:0]         stim_b,
    input  logic [WIDTH_Y-1:0]         dut_y,
    input  logic [WIDTH_Y-1:0]         ref_y,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [WIDTH_A+WIDTH_B:0]   mismatch_cnt,
    output logic [WIDTH_A-1:0]         first_fail_a,
    output logic [WIDTH_B-1:0]         first_fail_b,
    output logic                       fail_seen
);

    // Combined {a,b} vector index width and mismatch counter width. The
    // counter holds up to 2^(WIDTH_A+WIDTH_B), so one extra bit suffices.
    localparam int                   c_IDX_W    = WIDTH_A + WIDTH_B;
    localparam int                   c_CNT_W    = c_IDX_W + 1;
    localparam logic [7:0]           c_HOLD     = 8'(HOLD_CYCLES);
    localparam logic [c_IDX_W-1:0]   c_IDX_ONE  = {{(c_IDX_W-1){1'b0}}, 1'b1};
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE  = {{(c_CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                 r_state;
    logic [c_IDX_W-1:0]     r_idx;          // {a, b}: incrementing it gives b-inner ordering
    logic [7:0]             r_settle;
    logic [c_CNT_W-1:0]     r_mismatch;
    logic [WIDTH_A-1:0]     r_ff_a;
    logic [WIDTH_B-1:0]     r_ff_b;
    logic                   r_fail_seen;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;

    logic                   w_fail;
    logic                   w_last;
    logic                   w_stop;

    // Mismatch unless the results are provably equal: an X/Z compare makes
    // the if-condition unknown, which falls through and keeps w_fail high.
    always_comb begin
        w_fail = 1'b1;
        if (dut_y == ref_y) begin
            w_fail = 1'b0;
        end
    end

    assign w_last = &r_idx;

`ifdef EXHAUSTIVE_SWEEP_STOP_ON_FAIL_EN
    assign w_stop = w_fail;
`else
    assign w_stop = 1'b0;
`endif

    // Sweep control FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_settle    <= 8'd0;
            r_mismatch  <= '0;
            r_ff_a      <= '0;
            r_ff_b      <= '0;
            r_fail_seen <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // A fresh sweep clears all results of the previous one.
                    if (start) begin
                        r_state     <= S_SETTLE;
                        r_idx       <= '0;
                        r_settle    <= c_HOLD;
                        r_mismatch  <= '0;
                        r_ff_a      <= '0;
                        r_ff_b      <= '0;
                        r_fail_seen <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end

                S_SETTLE: begin
                    // The compare cycle follows the last settle cycle, so a
                    // count of 1 (or a defensive 0) hands over to CHECK.
                    if (r_settle <= 8'd1) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_settle <= r_settle - 8'd1;
                    end
                end

                S_CHECK: begin
                    if (w_fail) begin
                        r_mismatch <= r_mismatch + c_CNT_ONE;
                        if (!r_fail_seen) begin
                            r_ff_a      <= r_idx[c_IDX_W-1:WIDTH_B];
                            r_ff_b      <= r_idx[WIDTH_B-1:0];
                            r_fail_seen <= 1'b1;
                        end
                    end

                    if (w_last || w_stop) begin
                        // Index is left untouched so the final (or failing)
                        // vector stays on stim_a/stim_b in DONE.
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= ~(r_fail_seen | w_fail);
                    end else begin
                        r_state  <= S_SETTLE;
                        r_idx    <= r_idx + c_IDX_ONE;
                        r_settle <= c_HOLD;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign stim_a       = r_idx[c_IDX_W-1:WIDTH_B];
    assign stim_b       = r_idx[WIDTH_B-1:0];
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign mismatch_cnt = r_mismatch;
    assign first_fail_a = r_ff_a;
    assign first_fail_b = r_ff_b;
    assign fail_seen    = r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_exhaustive_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_exhaustive_sweep_checker
// Description : Directed self-checking bench for exhaustive_sweep_checker.
//               Instance u_dut uses default parameters; u_dut2 uses
//               WIDTH_A=WIDTH_B=WIDTH_Y=2 with HOLD_CYCLES=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exhaustive_sweep_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        start2;

    // Default instance signals
    logic [2:0]  stim_a, stim_b, dut_y, ref_y;
    logic        busy, done, pass, fail_seen;
    logic [6:0]  mismatch_cnt;
    logic [2:0]  ff_a, ff_b;
    logic [63:0] bad, xbad;

    // Small instance signals
    logic [1:0]  stim2_a, stim2_b, dut2_y, ref2_y;
    logic        busy2, done2, pass2, fail2;
    logic [4:0]  mm2;
    logic [1:0]  ff2_a, ff2_b;
    logic        glitch2;

    int checks   = 0;
    int failures = 0;
    int n;

    // Golden model a^b; the DUT side is corrupted or made unknown per vector.
    always_comb begin
        ref_y = stim_a ^ stim_b;
        dut_y = ref_y;
        if (bad[{stim_a, stim_b}])  dut_y = ~ref_y;
        if (xbad[{stim_a, stim_b}]) dut_y = 'x;
    end

    always_comb begin
        ref2_y = stim2_a ^ stim2_b;
        dut2_y = glitch2 ? ~ref2_y : ref2_y;
    end

    exhaustive_sweep_checker u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stim_a       (stim_a),
        .stim_b       (stim_b),
        .dut_y        (dut_y),
        .ref_y        (ref_y),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_cnt (mismatch_cnt),
        .first_fail_a (ff_a),
        .first_fail_b (ff_b),
        .fail_seen    (fail_seen)
    );

    exhaustive_sweep_checker #(
        .WIDTH_A     (2),
        .WIDTH_B     (2),
        .WIDTH_Y     (2),
        .HOLD_CYCLES (3)
    ) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .start        (start2),
        .stim_a       (stim2_a),
        .stim_b       (stim2_b),
        .dut_y        (dut2_y),
        .ref_y        (ref2_y),
        .busy         (busy2),
        .done         (done2),
        .pass         (pass2),
        .mismatch_cnt (mm2),
        .first_fail_a (ff2_a),
        .first_fail_b (ff2_b),
        .fail_seen    (fail2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. Pulses start, then follows the sweep one cycle at
    // a time: after start-edge P0, edge Pn shows vector n/2 (HOLD_CYCLES=1).
    task automatic sweep1(input int exp_n, input bit pulse40, output int cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            chk("busy_high", busy, 1);
            chk("done_low", done, 0);
            chk("stim_a_seq", stim_a, (cyc / 2) >> 3);
            chk("stim_b_seq", stim_b, (cyc / 2) & 7);
            start = (pulse40 && cyc == 40);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("sweep_len", cyc, exp_n);
        chk("busy_after", busy, 0);
        chk("done_after", done, 1);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start2  = 1'b0;
        bad     = '0;
        xbad    = '0;
        glitch2 = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail_seen", fail_seen, 0);
        chk("rst_mm", mismatch_cnt, 0);
        chk("rst_stim_a", stim_a, 0);
        chk("rst_stim_b", stim_b, 0);
        chk("rst_ff_a", ff_a, 0);
        chk("rst_ff_b", ff_b, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_done2", done2, 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean sweep with a stray start at cycle 40 (ignored)
        sweep1(128, 1'b1, n);
        chk("A_pass", pass, 1);
        chk("A_mm", mismatch_cnt, 0);
        chk("A_fail_seen", fail_seen, 0);
        chk("A_stim_a_final", stim_a, 7);
        chk("A_stim_b_final", stim_b, 7);
        repeat (3) @(negedge clk);
        chk("A_done_held", done, 1);
        chk("A_pass_held", pass, 1);

        // Single failure at (5,2), started from DONE
        bad[42] = 1'b1;
`ifdef EXHAUSTIVE_SWEEP_STOP_ON_FAIL_EN
        sweep1(86, 1'b0, n);
        chk("B_stim_a_frozen", stim_a, 5);
        chk("B_stim_b_frozen", stim_b, 2);
`else
        sweep1(128, 1'b0, n);
        chk("B_stim_a_final", stim_a, 7);
        chk("B_stim_b_final", stim_b, 7);
`endif
        chk("B_mm", mismatch_cnt, 1);
        chk("B_fail_seen", fail_seen, 1);
        chk("B_ff_a", ff_a, 5);
        chk("B_ff_b", ff_b, 2);
        chk("B_pass", pass, 0);

        // Unknown DUT output at (1,3), wrong value at (6,0)
        bad      = '0;
        xbad[11] = 1'b1;
        bad[48]  = 1'b1;
`ifdef EXHAUSTIVE_SWEEP_STOP_ON_FAIL_EN
        sweep1(24, 1'b0, n);
        chk("C_mm", mismatch_cnt, 1);
`else
        sweep1(128, 1'b0, n);
        chk("C_mm", mismatch_cnt, 2);
`endif
        chk("C_ff_a", ff_a, 1);
        chk("C_ff_b", ff_b, 3);
        chk("C_pass", pass, 0);

        // Asynchronous reset mid-SETTLE at vector (3,4); (3,3) fails first
        xbad    = '0;
        bad     = '0;
        bad[27] = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        repeat (56) @(negedge clk);
`ifdef EXHAUSTIVE_SWEEP_STOP_ON_FAIL_EN
        chk("D_pre_done", done, 1);
        chk("D_pre_stim_b", stim_b, 3);
`else
        chk("D_pre_busy", busy, 1);
        chk("D_pre_stim_b", stim_b, 4);
`endif
        chk("D_pre_stim_a", stim_a, 3);
        chk("D_pre_mm", mismatch_cnt, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("D_rst_busy", busy, 0);
        chk("D_rst_done", done, 0);
        chk("D_rst_stim_a", stim_a, 0);
        chk("D_rst_stim_b", stim_b, 0);
        chk("D_rst_mm", mismatch_cnt, 0);
        chk("D_rst_fail_seen", fail_seen, 0);
        chk("D_rst_ff_a", ff_a, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = '0;
        @(negedge clk);
        sweep1(128, 1'b0, n);
        chk("D_resweep_pass", pass, 1);
        chk("D_resweep_mm", mismatch_cnt, 0);

        // Small instance: 4-cycle vectors, dut2_y wrong except in the compare cycle
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 300) begin
            glitch2 = ((n % 4) != 3);
            chk("E_busy2", busy2, 1);
            chk("E_stim2_a", stim2_a, (n / 4) >> 2);
            chk("E_stim2_b", stim2_b, (n / 4) & 3);
            @(negedge clk);
            n++;
        end
        glitch2 = 1'b0;
        chk("E_len", n, 64);
        chk("E_done2", done2, 1);
        chk("E_busy2_after", busy2, 0);
        chk("E_pass2", pass2, 1);
        chk("E_mm2", mm2, 0);
        chk("E_fail2", fail2, 0);
        chk("E_stim2_a_final", stim2_a, 3);
        chk("E_stim2_b_final", stim2_b, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
